// File: rtl/ee_pkg.sv
// Shared types and default timing for the EEPROM timing sequencer.
// EE_SEQ_VERIFY_EN adds the read-back verify state VF_P.
package ee_pkg;

    typedef enum logic [1:0] {
        EE_READ        = 2'd0,
        EE_WRITE       = 2'd1,
        EE_ERASE       = 2'd2,
        EE_ERASE_WRITE = 2'd3
    } ee_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_P = 3'd1,
        ER_P = 3'd2,
        ER_R = 3'd3,
        WR_P = 3'd4,
        WR_R = 3'd5,
        FIN  = 3'd6
`ifdef EE_SEQ_VERIFY_EN
        , VF_P = 3'd7
`endif
    } state_t;

    localparam int T_RD_DEF  = 2;
    localparam int T_WR_DEF  = 16;
    localparam int T_ER_DEF  = 32;
    localparam int T_REC_DEF = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ee_tmr.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module ee_tmr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ee_seq.sv
// EEPROM macro timing sequencer: turns one-cycle core commands into timed RD/WR/ERASE strobes.
// Optional read-back verify after every write is enabled by EE_SEQ_VERIFY_EN.
module ee_seq
    import ee_pkg::*;
#(
    parameter int T_RD  = T_RD_DEF,
    parameter int T_WR  = T_WR_DEF,
    parameter int T_ER  = T_ER_DEF,
    parameter int T_REC = T_REC_DEF
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic [7:0] ee_a,
    output logic [7:0] ee_d,
    output logic       ee_rd,
    output logic       ee_wr,
    output logic       ee_erase,
    input  logic [7:0] ee_q,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(max4(T_RD, T_WR, T_ER, T_REC)) + 1;
    localparam logic [CW-1:0] LD_RD  = CW'(T_RD - 1);
    localparam logic [CW-1:0] LD_WR  = CW'(T_WR - 1);
    localparam logic [CW-1:0] LD_ER  = CW'(T_ER - 1);
    localparam logic [CW-1:0] LD_REC = CW'(T_REC - 1);

    state_t        state, state_nxt;
    ee_op_t        op_q, op_nxt;
    logic          busy_nxt, done_nxt, err_nxt;
    logic          rd_nxt, wr_nxt, er_nxt;
    logic [7:0]    rdata_nxt, a_nxt, d_nxt;
    logic          ld;
    logic [CW-1:0] ld_val;
    logic          zero;

    ee_tmr #(.W(CW)) u_tmr (
        .clk      (clk),
        .nreset   (nreset),
        .load     (ld),
        .load_val (ld_val),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            op_q     <= EE_READ;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            err      <= 1'b0;
            ee_a     <= 8'h00;
            ee_d     <= 8'h00;
            ee_rd    <= 1'b0;
            ee_wr    <= 1'b0;
            ee_erase <= 1'b0;
        end else begin
            state    <= state_nxt;
            op_q     <= op_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            rdata    <= rdata_nxt;
            err      <= err_nxt;
            ee_a     <= a_nxt;
            ee_d     <= d_nxt;
            ee_rd    <= rd_nxt;
            ee_wr    <= wr_nxt;
            ee_erase <= er_nxt;
        end
    end

    // Strobe next-values are set only on the cycle that enters or stays in a pulse state,
    // so the registered strobe lines up exactly with the state and never overlaps.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = err;
        rdata_nxt = rdata;
        a_nxt     = ee_a;
        d_nxt     = ee_d;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        er_nxt    = 1'b0;
        ld        = 1'b0;
        ld_val    = '0;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (cmd_valid) begin
                    op_nxt   = ee_op_t'(cmd_op);
                    a_nxt    = cmd_addr;
                    d_nxt    = cmd_wdata;
                    err_nxt  = 1'b0;
                    busy_nxt = 1'b1;
                    ld       = 1'b1;
                    case (ee_op_t'(cmd_op))
                        EE_READ:  begin state_nxt = RD_P; ld_val = LD_RD; rd_nxt = 1'b1; end
                        EE_WRITE: begin state_nxt = WR_P; ld_val = LD_WR; wr_nxt = 1'b1; end
                        default:  begin state_nxt = ER_P; ld_val = LD_ER; er_nxt = 1'b1; end
                    endcase
                end
            end
            RD_P: begin
                if (zero) begin
                    rdata_nxt = ee_q;
                    state_nxt = FIN;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    rd_nxt = 1'b1;
                end
            end
            ER_P: begin
                if (zero) begin
                    state_nxt = ER_R;
                    ld        = 1'b1;
                    ld_val    = LD_REC;
                end else begin
                    er_nxt = 1'b1;
                end
            end
            ER_R: begin
                if (zero) begin
                    if (op_q == EE_ERASE_WRITE) begin
                        state_nxt = WR_P;
                        ld        = 1'b1;
                        ld_val    = LD_WR;
                        wr_nxt    = 1'b1;
                    end else begin
                        state_nxt = FIN;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            WR_P: begin
                if (zero) begin
                    state_nxt = WR_R;
                    ld        = 1'b1;
                    ld_val    = LD_REC;
                end else begin
                    wr_nxt = 1'b1;
                end
            end
            WR_R: begin
                if (zero) begin
`ifdef EE_SEQ_VERIFY_EN
                    state_nxt = VF_P;
                    ld        = 1'b1;
                    ld_val    = LD_RD;
                    rd_nxt    = 1'b1;
`else
                    state_nxt = FIN;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
`endif
                end
            end
`ifdef EE_SEQ_VERIFY_EN
            VF_P: begin
                if (zero) begin
                    rdata_nxt = ee_q;
                    err_nxt   = (ee_q != ee_d);
                    state_nxt = FIN;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    rd_nxt = 1'b1;
                end
            end
`endif
            FIN: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: doc/ee_seq.md
Name: ee_seq

Overview:
- Timing sequencer between the risc4b core EEPROM command interface and the eeprom macro.
- Accepts one-cycle commands from the core: READ, WRITE, ERASE, ERASE_WRITE.
- Drives the macro RD/WR/ERASE strobes with programmed pulse and recovery times, latches read data and reports busy/done.
- Replaces the direct ee_ctrl wiring in the chip top level; firmware polls busy instead of counting cycles.

Parameters:
- T_RD, 2: RD pulse width in clk cycles (min 1).
- T_WR, 16: WR pulse width in clk cycles (min 1).
- T_ER, 32: ERASE pulse width in clk cycles (min 1).
- T_REC, 2: recovery cycles, all strobes low, after each WR/ERASE pulse (min 1).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe; sampled only when busy=0
- cmd_op  in  2  0=READ, 1=WRITE, 2=ERASE, 3=ERASE_WRITE
- cmd_addr  in  8  EEPROM byte address
- cmd_wdata  in  8  write data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- rdata  out  8  last read data (held)
- err  out  1  sticky error flag; cleared by the next accepted command
- ee_a  out  8  macro address
- ee_d  out  8  macro write data
- ee_rd  out  1  macro RD
- ee_wr  out  1  macro WR
- ee_erase  out  1  macro ERASE
- ee_q  in  8  macro read data

Behaviour:
- Reset (asynchronous, nreset=0): state IDLE; busy=0, done=0, rdata=0, err=0, ee_a=0, ee_d=0, all strobes 0; counter=0.
- The clock is clk; the reset is nreset, asynchronous and active-low. All registers use this single clock.
- All outputs are registered. At most one strobe is high in any cycle.
- Accept condition: IDLE and cmd_valid=1.
  - Cycle N: latch addr/wdata/op into ee_a/ee_d/op_q; busy=1 from cycle N+1; err cleared.
- cmd_valid while busy=1 is ignored. The bench checks that no state change occurs.
- States and transitions:
  - IDLE: on accept, go to RD_P (READ), WR_P (WRITE), or ER_P (ERASE or ERASE_WRITE).
  - RD_P: ee_rd=1 for T_RD cycles; ee_q is sampled into rdata in the last cycle; then FIN.
  - ER_P: ee_erase=1 for T_ER cycles, then ER_R.
  - ER_R: strobes low for T_REC cycles; then WR_P if op=ERASE_WRITE, else FIN.
  - WR_P: ee_wr=1 for T_WR cycles, then WR_R.
  - WR_R: strobes low for T_REC cycles, then FIN.
  - FIN: done=1, busy=0 for one cycle; return to IDLE. A cmd_valid in FIN is ignored.
- Counter:
  - Width is $clog2(max(T_RD,T_WR,T_ER,T_REC))+1.
  - Loaded with T-1 on state entry; decrements to 0; state exits when it reaches 0.
  - Therefore a pulse lasts exactly T cycles.
- Latency, from the accept edge to the done pulse:
  - READ = T_RD+1
  - WRITE = T_WR+T_REC+1
  - ERASE = T_ER+T_REC+1
  - ERASE_WRITE = T_ER+T_REC+T_WR+T_REC+1
- ee_a/ee_d are held stable through the whole sequence and until the next accept.
- Reset mid-sequence: strobes drop immediately (asynchronously); no partial done pulse is produced.

Optional Feature:
- Macro EE_SEQ_VERIFY_EN.
- Defined:
  - After WR_R, extra state VF_P asserts ee_rd for T_RD cycles and compares ee_q with ee_d in the last cycle.
  - A mismatch sets err=1. The read value is also written to rdata.
  - WRITE and ERASE_WRITE latency grows by T_RD.
- Undefined: VF_P does not exist and err stays 0.

Decomposition:
- Package ee_pkg:
  - typedef enum logic [1:0] ee_op_t {EE_READ, EE_WRITE, EE_ERASE, EE_ERASE_WRITE}.
  - typedef enum state_t for the FSM.
  - Default timing localparams.
- One natural sub-module, ee_tmr: loadable down-counter with a zero flag, parameterised width.

Test Plan:
- READ at addr 0x3C, with ee_q=0xA5 during the pulse -> ee_rd high for exactly 2 cycles; done 3 cycles after accept; rdata=0xA5; busy=1 for 2 cycles.
- WRITE addr 0x10, data 0x5A -> ee_wr high for 16 cycles with ee_a=0x10, ee_d=0x5A; 2 recovery cycles; done at cycle 19.
- ERASE_WRITE addr 0xFF -> ee_erase high 32 cycles, 2 low, ee_wr high 16, 2 low; done at cycle 53; ee_erase and ee_wr never overlap.
- cmd_valid pulsed every cycle during a WRITE -> only the first is accepted; ee_a/ee_d unchanged; exactly one done.
- nreset pulsed low at cycle 8 of ER_P -> ee_erase=0 asynchronously; busy=0; no done; next READ works normally.
- With EE_SEQ_VERIFY_EN, WRITE 0x5A while ee_q returns 0x58 -> err=1, rdata=0x58, done at cycle 21; the next accepted command clears err.
